// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MIPS memory-access stage.
//   - mem_op_e   : memory operation encodings carried from EX
//   - mem_state_e: stage state machine encoding
//   - default datapath and register-address widths
//   - helpers that classify an operation (load / store / word access)
// Build option: MEM_ALIGN_CHECK_EN (used by mem_stage) enables misaligned
// word-access detection.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LW   = 3'd1,
        MEM_LB   = 3'd2,
        MEM_LBU  = 3'd3,
        MEM_SW   = 3'd4,
        MEM_SB   = 3'd5
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // Raw encodings 6 and 7 are reserved and behave exactly like NONE.
    function automatic mem_op_e decode_op(input logic [2:0] raw);
        mem_op_e op;
        case (raw)
            3'd1:    op = MEM_LW;
            3'd2:    op = MEM_LB;
            3'd3:    op = MEM_LBU;
            3'd4:    op = MEM_SW;
            3'd5:    op = MEM_SB;
            default: op = MEM_NONE;
        endcase
        return op;
    endfunction

    function automatic logic op_is_load(input mem_op_e op);
        return (op == MEM_LW) || (op == MEM_LB) || (op == MEM_LBU);
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SB);
    endfunction

    function automatic logic op_is_word(input mem_op_e op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational little-endian byte-lane steering for the memory stage.
// Request side (from the op being issued):
//   i_st_op, i_st_lane, i_store_data -> o_be, o_wdata
// Response side (from the op in flight):
//   i_ld_op, i_ld_lane, i_rdata      -> o_ld_data
// Lane 0 is bits 7:0.
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  mem_op_e           i_st_op,
    input  logic [1:0]        i_st_lane,
    input  logic [DATA_W-1:0] i_store_data,
    input  mem_op_e           i_ld_op,
    input  logic [1:0]        i_ld_lane,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [7:0] w_byte;

    // Byte enables and store data; byte ops replicate the byte on every lane
    // so the memory only needs to honour the enables.
    always_comb begin
        o_be    = 4'h0;
        o_wdata = i_store_data;
        case (i_st_op)
            MEM_LW, MEM_SW: o_be = 4'hF;
            MEM_LB, MEM_LBU: o_be = 4'b0001 << i_st_lane;
            MEM_SB: begin
                o_be    = 4'b0001 << i_st_lane;
                o_wdata = {(DATA_W/8){i_store_data[7:0]}};
            end
            default: o_be = 4'h0;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_op)
            MEM_LB:  o_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            MEM_LBU: o_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage MIPS pipeline. Accepts an operation
// from EX, performs loads/stores over a req/ack data-memory bus while
// stalling EX, and presents the write-back result to WB.
//
// Ports:
//   clk, rst (async, active-low)
//   EX side : in_valid, in_ready, mem_op, alu_result, store_data,
//             write_reg_en_in, write_reg_addr_in, stall_out
//   Memory  : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
//             dmem_rdata, dmem_ack
//   WB side : wb_valid, wb_write_reg_en, wb_write_reg_addr, wb_data
//   align_err (only when MEM_ALIGN_CHECK_EN is defined)
//
// Build option: MEM_ALIGN_CHECK_EN - misaligned LW/SW are not issued; they
// retire in the next cycle with align_err and no register write.
// ---------------------------------------------------------------------------
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            mem_op,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  write_reg_en_in,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  wb_write_reg_en,
    output logic [REG_ADDR_W-1:0] wb_write_reg_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  stall_out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  align_err
`endif
);

    mem_state_e            r_state;
    mem_state_e            w_next_state;

    mem_op_e               r_op;
    logic [1:0]            r_lane;
    logic                  r_we;
    logic [DATA_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [3:0]            r_be;
    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_waddr;

    logic                  r_wb_valid;
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]     r_wb_data;

    mem_op_e               w_op;
    logic [1:0]            w_lane;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_done;
    logic [3:0]            w_st_be;
    logic [DATA_W-1:0]     w_st_wdata;
    logic [DATA_W-1:0]     w_ld_data;

    assign w_op     = decode_op(mem_op);
    assign w_lane   = alu_result[1:0];
    assign w_is_mem = op_is_load(w_op) || op_is_store(w_op);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_err;
    assign w_misalign = op_is_word(w_op) && (w_lane != 2'b00);
    assign align_err  = r_align_err;
`else
    assign w_misalign = 1'b0;
`endif

    // A misaligned word op never reaches the bus; it retires like NONE.
    assign w_issue = w_is_mem && !w_misalign;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_st_op      (w_op),
        .i_st_lane    (w_lane),
        .i_store_data (store_data),
        .i_ld_op      (r_op),
        .i_ld_lane    (r_lane),
        .i_rdata      (dmem_rdata),
        .o_be         (w_st_be),
        .o_wdata      (w_st_wdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // dmem_req comes straight from the state so an async reset drops it
    // in the same instant.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        in_ready     = 1'b0;
        dmem_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_issue) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= MEM_NONE;
            r_lane     <= 2'b00;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'h0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
            if (w_accept) begin
                if (w_issue) begin
                    r_op    <= w_op;
                    r_lane  <= w_lane;
                    r_we    <= op_is_store(w_op);
                    r_addr  <= {alu_result[DATA_W-1:2], 2'b00};
                    r_wdata <= w_st_wdata;
                    r_be    <= w_st_be;
                    r_wen   <= op_is_store(w_op) ? 1'b0 : write_reg_en_in;
                    r_waddr <= write_reg_addr_in;
                end else begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= alu_result;
                    r_wb_addr  <= write_reg_addr_in;
                    r_wb_en    <= w_misalign ? 1'b0 : write_reg_en_in;
`ifdef MEM_ALIGN_CHECK_EN
                    r_align_err <= w_misalign;
`endif
                end
            end
            // Stores leave wb_data untouched; their write enable is already 0.
            if (w_done) begin
                r_wb_valid <= 1'b1;
                r_wb_en    <= r_wen;
                r_wb_addr  <= r_waddr;
                if (!r_we) begin
                    r_wb_data <= w_ld_data;
                end
            end
        end
    end

    assign stall_out         = ~in_ready;
    assign dmem_we           = r_we;
    assign dmem_addr         = r_addr;
    assign dmem_wdata        = r_wdata;
    assign dmem_be           = r_be;
    assign wb_valid          = r_wb_valid;
    assign wb_write_reg_en   = r_wb_en;
    assign wb_write_reg_addr = r_wb_addr;
    assign wb_data           = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed testbench for mem_stage. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_write_reg_en;
    logic [4:0]  wb_write_reg_addr;
    logic [31:0] wb_data;
    logic        stall_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_op            (mem_op),
        .alu_result        (alu_result),
        .store_data        (store_data),
        .write_reg_en_in   (write_reg_en_in),
        .write_reg_addr_in (write_reg_addr_in),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .wb_valid          (wb_valid),
        .wb_write_reg_en   (wb_write_reg_en),
        .wb_write_reg_addr (wb_write_reg_addr),
        .wb_data           (wb_data),
        .stall_out         (stall_out)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_err         (align_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 200000 required");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] alu,
                                 input logic [31:0] sd, input logic en, input logic [4:0] ra);
        in_valid          = v;
        mem_op            = op;
        alu_result        = alu;
        store_data        = sd;
        write_reg_en_in   = en;
        write_reg_addr_in = ra;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Issue a memory op, ack it in its first BUSY cycle, and leave the
    // sampling point at A+1.
    task automatic singleAckOp(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                               input logic [4:0] ra, input logic [31:0] rdata);
        applyStimulus(1'b1, op, addr, sd, 1'b1, ra);
        @(negedge clk);
        idleInputs();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idleInputs();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_stall", {31'b0, stall_out}, 32'd0);
        checkOutput("rst_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_be", {28'b0, dmem_be}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // NONE op, then a second NONE immediately after
        applyStimulus(1'b1, 3'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd5);
        @(negedge clk);
        checkOutput("none_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("none_wb_data", wb_data, 32'h1234_5678);
        checkOutput("none_wb_addr", {27'b0, wb_write_reg_addr}, 32'd5);
        checkOutput("none_wb_en", {31'b0, wb_write_reg_en}, 32'd1);
        checkOutput("none_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(1'b1, 3'd0, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd7);
        @(negedge clk);
        checkOutput("none2_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("none2_wb_data", wb_data, 32'hCAFE_F00D);
        checkOutput("none2_wb_en", {31'b0, wb_write_reg_en}, 32'd0);
        idleInputs();
        @(negedge clk);
        checkOutput("hold_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("hold_wb_data", wb_data, 32'hCAFE_F00D);
        checkOutput("hold_wb_addr", {27'b0, wb_write_reg_addr}, 32'd7);

        // Reserved encoding behaves as NONE
        applyStimulus(1'b1, 3'd6, 32'h0000_0ABC, 32'h0, 1'b1, 5'd2);
        @(negedge clk);
        idleInputs();
        checkOutput("op6_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("op6_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("op6_wb_data", wb_data, 32'h0000_0ABC);

        // LW at 0x100, ack in the third BUSY cycle; EX holds a NONE meanwhile
        applyStimulus(1'b1, 3'd1, 32'h0000_0100, 32'h0, 1'b1, 5'd9);
        @(negedge clk);
        applyStimulus(1'b1, 3'd0, 32'h5555_0000, 32'h0, 1'b1, 5'd10);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lw_req_%0d", i), {31'b0, dmem_req}, 32'd1);
            checkOutput($sformatf("lw_stall_%0d", i), {31'b0, stall_out}, 32'd1);
            checkOutput($sformatf("lw_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("lw_addr_%0d", i), dmem_addr, 32'h0000_0100);
            checkOutput($sformatf("lw_be_%0d", i), {28'b0, dmem_be}, 32'hF);
            checkOutput($sformatf("lw_we_%0d", i), {31'b0, dmem_we}, 32'd0);
            checkOutput($sformatf("lw_wb_valid_%0d", i), {31'b0, wb_valid}, 32'd0);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("lw_req_after", {31'b0, dmem_req}, 32'd0);
        checkOutput("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        checkOutput("lw_wb_addr", {27'b0, wb_write_reg_addr}, 32'd9);
        checkOutput("lw_wb_en", {31'b0, wb_write_reg_en}, 32'd1);
        checkOutput("lw_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        idleInputs();
        checkOutput("held_none_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("held_none_wb_data", wb_data, 32'h5555_0000);
        checkOutput("held_none_wb_addr", {27'b0, wb_write_reg_addr}, 32'd10);

        // LB at 0x103: byte 0x80 sign-extended
        applyStimulus(1'b1, 3'd2, 32'h0000_0103, 32'h0, 1'b1, 5'd11);
        @(negedge clk);
        idleInputs();
        checkOutput("lb_addr", dmem_addr, 32'h0000_0100);
        checkOutput("lb_be", {28'b0, dmem_be}, 32'h8);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FF7F;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("lb_wb_data", wb_data, 32'hFFFF_FF80);

        // LBU on the same data: zero-extended
        singleAckOp(3'd3, 32'h0000_0103, 32'h0, 5'd12, 32'h80FF_FF7F);
        checkOutput("lbu_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("lbu_wb_data", wb_data, 32'h0000_0080);
        checkOutput("lbu_wb_addr", {27'b0, wb_write_reg_addr}, 32'd12);

        // LB lane 0, positive byte
        singleAckOp(3'd2, 32'h0000_0200, 32'h0, 5'd13, 32'h80FF_FF7F);
        checkOutput("lb0_wb_data", wb_data, 32'h0000_007F);

        // SB at 0x102
        applyStimulus(1'b1, 3'd5, 32'h0000_0102, 32'h0000_00AB, 1'b1, 5'd3);
        @(negedge clk);
        idleInputs();
        checkOutput("sb_req", {31'b0, dmem_req}, 32'd1);
        checkOutput("sb_we", {31'b0, dmem_we}, 32'd1);
        checkOutput("sb_be", {28'b0, dmem_be}, 32'h4);
        checkOutput("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_addr", dmem_addr, 32'h0000_0100);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("sb_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("sb_wb_en", {31'b0, wb_write_reg_en}, 32'd0);

        // Stray ack in IDLE is ignored
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("idle_ack_wb_valid", {31'b0, wb_valid}, 32'd0);

        // SW at 0x101: misaligned word store
        applyStimulus(1'b1, 3'd4, 32'h0000_0101, 32'h1122_3344, 1'b1, 5'd4);
        @(negedge clk);
        idleInputs();
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("sw_mis_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("sw_mis_align_err", {31'b0, align_err}, 32'd1);
        checkOutput("sw_mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("sw_mis_wb_en", {31'b0, wb_write_reg_en}, 32'd0);
        checkOutput("sw_mis_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        checkOutput("sw_mis_align_err_drop", {31'b0, align_err}, 32'd0);
`else
        checkOutput("sw_req", {31'b0, dmem_req}, 32'd1);
        checkOutput("sw_addr", dmem_addr, 32'h0000_0100);
        checkOutput("sw_be", {28'b0, dmem_be}, 32'hF);
        checkOutput("sw_wdata", dmem_wdata, 32'h1122_3344);
        checkOutput("sw_we", {31'b0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("sw_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("sw_wb_en", {31'b0, wb_write_reg_en}, 32'd0);
`endif

        // Reset asserted mid-BUSY on an LW
        applyStimulus(1'b1, 3'd1, 32'h0000_0200, 32'h0, 1'b1, 5'd8);
        @(negedge clk);
        idleInputs();
        checkOutput("abort_req_before", {31'b0, dmem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_req_async", {31'b0, dmem_req}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        checkOutput("abort_wb_valid_rst", {31'b0, wb_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("abort_wb_valid_rel", {31'b0, wb_valid}, 32'd0);
        checkOutput("abort_req_rel", {31'b0, dmem_req}, 32'd0);
        checkOutput("abort_in_ready_rel", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_wb_data", wb_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
